// File: rtl/shifter_funnel_pipe.sv
// Two-stage pipelined funnel shifter (SRF/SLF/SRA/ROR) with a valid/ready stream.
// Stage 1 does operand substitution, reflection and the coarse shift; stage 2 does the fine shift.
module shifter_funnel_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_h,
    input  logic [WIDTH-1:0] in_l,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAGW-1:0]  out_tag
);

    localparam logic [1:0] OP_SRF = 2'd0;
    localparam logic [1:0] OP_SLF = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    function automatic logic [WIDTH-1:0] reflect(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Handshake: a transfer happens on a rising edge where valid && ready; valid and
    // payload are held stable by the producer until that edge, ready may depend on state
    // and on out_ready but never on in_valid.
    logic                 s1_valid_q;
    logic [2*WIDTH-1:0]   s1_funnel_q;
    logic [1:0]           s1_fine_q;
    logic [1:0]           s1_op_q;
    logic [TAGW-1:0]      s1_tag_q;

    logic                 s2_valid_q;
    logic [WIDTH-1:0]     s2_y_q;
    logic [TAGW-1:0]      s2_tag_q;

    logic                 s1_load;
    logic                 s2_load;
    logic                 accept;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign accept   = in_valid && in_ready;

    // SLF becomes a right funnel on reflected, swapped operands: rev({L,H}) = {rev(H), rev(L)}.
    logic [WIDTH-1:0]   h_sub;
    logic [WIDTH-1:0]   l_sub;
    logic [SHW-1:0]     coarse_amt;
    logic [2*WIDTH-1:0] s1_funnel_d;

    always_comb begin
        h_sub = in_h;
        l_sub = in_l;
        case (in_op)
            OP_SLF: begin
                h_sub = reflect(in_h);
                l_sub = reflect(in_l);
            end
            OP_SRA:  h_sub = {WIDTH{in_l[WIDTH-1]}};
            OP_ROR:  h_sub = in_l;
            default: h_sub = in_h;
        endcase
    end

    assign coarse_amt  = {in_shamt[SHW-1:2], 2'b00};
    assign s1_funnel_d = {h_sub, l_sub} >> coarse_amt;

    logic [WIDTH-1:0] fine_lo;
    logic [WIDTH-1:0] s2_y_d;

    assign fine_lo = WIDTH'(s1_funnel_q >> s1_fine_q);
    assign s2_y_d  = (s1_op_q == OP_SLF) ? reflect(fine_lo) : fine_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_funnel_q <= '0;
            s1_fine_q   <= '0;
            s1_op_q     <= '0;
            s1_tag_q    <= '0;
        end else if (s1_load) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_funnel_q <= s1_funnel_d;
                s1_fine_q   <= in_shamt[1:0];
                s1_op_q     <= in_op;
                s1_tag_q    <= in_tag;
            end
        end
    end

    // out_y/out_tag only change when a new result moves in, so they hold across bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_y_q     <= '0;
            s2_tag_q   <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_y_q   <= s2_y_d;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_y     = s2_y_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_shifter_funnel_pipe.sv
// Self-checking bench for shifter_funnel_pipe (WIDTH=32): modes, streaming, stalls, async reset, random sweep.
module tb_shifter_funnel_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int SW = 5;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_h;
    logic [W-1:0]  in_l;
    logic [SW-1:0] in_shamt;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic [TW-1:0] out_tag;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  exp_q[$];
    logic [TW-1:0] exp_tag_q[$];

    shifter_funnel_pipe #(.WIDTH(W), .TAGW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_h      (in_h),
        .in_l      (in_l),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference written straight from the mode equations (no reflection trick).
    function automatic logic [W-1:0] ref_y(input logic [W-1:0] h, input logic [W-1:0] l,
                                           input logic [SW-1:0] s, input logic [1:0] op);
        logic [2*W-1:0] f;
        case (op)
            2'd0: f = {h, l} >> s;
            2'd1: begin
                f = {l, h} << s;
                return f[2*W-1:W];
            end
            2'd2: f = {{W{l[W-1]}}, l} >> s;
            default: f = {l, l} >> s;
        endcase
        return f[W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [W-1:0] h, input logic [W-1:0] l,
                             input logic [SW-1:0] s, input logic [1:0] op, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_h     = h;
        in_l     = l;
        in_shamt = s;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_h = '0; in_l = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_y !== '0) begin errors++; $display("FAIL reset_out_y got=%h exp=0", out_y); end
        checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_modes();
        logic [W-1:0]  vh[5];
        logic [W-1:0]  vl[5];
        logic [SW-1:0] vs[5];
        logic [1:0]    vo[5];
        logic [W-1:0]  vy[5];
        vh[0] = 32'h0000_0003; vl[0] = 32'h8000_0001; vs[0] = 5'd4;  vo[0] = 2'd0; vy[0] = 32'h3800_0000;
        vh[1] = 32'hF000_0000; vl[1] = 32'h8000_0001; vs[1] = 5'd4;  vo[1] = 2'd1; vy[1] = 32'h0000_001F;
        vh[2] = 32'h1234_5678; vl[2] = 32'h8000_0000; vs[2] = 5'd31; vo[2] = 2'd2; vy[2] = 32'hFFFF_FFFF;
        vh[3] = 32'hFFFF_FFFF; vl[3] = 32'h0000_0001; vs[3] = 5'd1;  vo[3] = 2'd3; vy[3] = 32'h8000_0000;
        vh[4] = 32'hDEAD_BEEF; vl[4] = 32'h1234_5678; vs[4] = 5'd0;  vo[4] = 2'd0; vy[4] = 32'h1234_5678;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_req(vh[i], vl[i], vs[i], vo[i], 4'(i));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mode%0d_in_ready got=%b exp=1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mode%0d_early got=%b exp=0", i, out_valid); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid got=%b exp=1", i, out_valid); end
            checks++; if (out_y !== vy[i]) begin errors++; $display("FAIL mode%0d_y got=%h exp=%h", i, out_y, vy[i]); end
            checks++; if (out_tag !== 4'(i)) begin errors++; $display("FAIL mode%0d_tag got=%h exp=%h", i, out_tag, 4'(i)); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  sh[8];
        logic [W-1:0]  sl[8];
        logic [SW-1:0] ss[8];
        logic [1:0]    so[8];
        logic          exp_v;
        int            k;
        for (int i = 0; i < 8; i++) begin
            sh[i] = 32'h1111_1111 * (i + 1);
            sl[i] = 32'hA5A5_0000 + i * 32'h0101_0013;
            ss[i] = 5'(i * 3 + 1);
            so[i] = 2'(i % 4);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_v = (c >= 2 && c <= 9);
            checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); end
            if (exp_v) begin
                k = c - 2;
                checks++; if (out_tag !== 4'(k)) begin errors++; $display("FAIL stream_tag c=%0d got=%h exp=%h", c, out_tag, 4'(k)); end
                checks++; if (out_y !== ref_y(sh[k], sl[k], ss[k], so[k])) begin
                    errors++; $display("FAIL stream_y c=%0d got=%h exp=%h", c, out_y, ref_y(sh[k], sl[k], ss[k], so[k]));
                end
            end
            if (c < 8) drive_req(sh[c], sl[c], ss[c], so[c], 4'(c));
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int            sent = 0;
        int            got  = 0;
        logic          prev_stall = 1'b0;
        logic [W-1:0]  prev_y = '0;
        logic [TW-1:0] prev_tag = '0;
        logic [W-1:0]  h, l;
        logic [SW-1:0] s;
        logic [1:0]    op;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c < 7);
            #1;
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_y !== prev_y || out_tag !== prev_tag) begin
                    errors++; $display("FAIL bp_stable c=%0d got=%b/%h/%h exp=1/%h/%h", c, out_valid, out_y, out_tag, prev_y, prev_tag);
                end
            end
            if (c == 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one_buffered got=%b exp=1", in_ready); end
            end
            if (c == 2) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got=%b exp=0", in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra c=%0d got=%h exp=none", c, out_y);
                end else begin
                    if (out_y !== exp_q[0] || out_tag !== exp_tag_q[0]) begin
                        errors++; $display("FAIL bp_order c=%0d got=%h/%h exp=%h/%h", c, out_y, out_tag, exp_q[0], exp_tag_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_tag_q.pop_front());
                    got++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = out_y;
            prev_tag   = out_tag;
            if (sent < 4) begin
                h = 32'hC0DE_0000 | 32'(sent); l = 32'h8765_4321 ^ (32'(sent) << 8);
                s = 5'(7 * sent + 3); op = 2'(sent);
                drive_req(h, l, s, op, 4'(sent + 4));
                if (in_ready) begin
                    exp_q.push_back(ref_y(h, l, s, op));
                    exp_tag_q.push_back(4'(sent + 4));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++; if (got != 4 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count got=%0d exp=4", got); end
        exp_q.delete();
        exp_tag_q.delete();
    endtask

    task automatic test_simul_accept_complete();
        out_ready = 1'b0;
        @(negedge clk);
        drive_req(32'h0000_00FF, 32'h0000_0000, 5'd8, 2'd0, 4'd8);    // A: 0xFF000000
        @(negedge clk);
        drive_req(32'h0, 32'h0000_0010, 5'd4, 2'd3, 4'd9);            // B: 0x00000001
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_y !== 32'hFF00_0000) begin
            errors++; $display("FAIL simul_full got=%b/%h exp=1/ff000000", out_valid, out_y);
        end
        out_ready = 1'b1;
        drive_req(32'h0, 32'h0000_0001, 5'd31, 2'd1, 4'd10);          // C: 0x80000000
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_y !== 32'h0000_0001 || out_tag !== 4'd9) begin
            errors++; $display("FAIL simul_advance got=%b/%h/%h exp=1/00000001/9", out_valid, out_y, out_tag);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_y !== 32'h8000_0000 || out_tag !== 4'd10) begin
            errors++; $display("FAIL simul_next got=%b/%h/%h exp=1/80000000/a", out_valid, out_y, out_tag);
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        @(negedge clk);
        drive_req(32'h1, 32'h2, 5'd1, 2'd0, 4'd1);
        @(negedge clk);
        drive_req(32'h3, 32'h4, 5'd2, 2'd0, 4'd2);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_inflight got=%b exp=1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_clear got=%b exp=0", out_valid); end
        @(negedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready got=%b exp=1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_stale c=%0d got=%b exp=0", c, out_valid); end
        end
        drive_req(32'hAAAA_AAAA, 32'h5555_5555, 5'd16, 2'd0, 4'd7);  // 0xAAAA5555
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_y !== 32'hAAAA_5555 || out_tag !== 4'd7) begin
            errors++; $display("FAIL arst_first got=%b/%h/%h exp=1/aaaa5555/7", out_valid, out_y, out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int            n = 10000;
        int            sent = 0;
        int            got = 0;
        int            cyc = 0;
        int            shown = 0;
        logic [W-1:0]  h, l;
        logic [SW-1:0] s;
        logic [1:0]    op;
        logic [TW-1:0] tag;
        while ((sent < n || got < n) && cyc < 60000) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    if (shown < 10) $display("FAIL rand_extra cyc=%0d got=%h exp=none", cyc, out_y);
                    shown++;
                end else begin
                    if (out_y !== exp_q[0] || out_tag !== exp_tag_q[0]) begin
                        errors++;
                        if (shown < 10) $display("FAIL rand_y cyc=%0d got=%h/%h exp=%h/%h", cyc, out_y, out_tag, exp_q[0], exp_tag_q[0]);
                        shown++;
                    end
                    void'(exp_q.pop_front());
                    void'(exp_tag_q.pop_front());
                    got++;
                end
            end
            if (sent < n) begin
                h = $urandom; l = $urandom;
                s = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3)); tag = 4'($urandom_range(0, 15));
                drive_req(h, l, s, op, tag);
                if (in_ready) begin
                    exp_q.push_back(ref_y(h, l, s, op));
                    exp_tag_q.push_back(tag);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++; if (got != n) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got, n); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_simul_accept_complete();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
